reset_sequencer: RTL and testbench

//  Orders reset release across NUM_STAGES downstream domains. Each domain feeds its

---
 rtl/reset_sequencer.sv | 234 +++++++++++++++++++++++
 tb/tb_reset_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : reset_sequencer
// Purpose  : Releases NUM_STAGES downstream resets one at a time, in index
//            order. Each stage leaves reset only after the previous stage has
//            reported ready and a programmable gap has elapsed. Software can
//            restart the whole sequence at any time. Always-on clock domain.
// Ports    : CLK         clock, all logic on posedge
//            RST         synchronous active-high reset
//            SW_RST_REQ  one-cycle pulse, restarts the full sequence
//            STAGE_RDY   per-stage ready, already synchronous to CLK
//            STAGE_RST   per-stage reset, active high, registered
//            SEQ_BUSY    sequence in progress (not DONE and not FAULT)
//            SEQ_DONE    all stages released and ready
//            ERR         ready timeout occurred, sticky until restart
//            ERR_STAGE   index of the stage that timed out
// Options  : RST_SEQ_TIMEOUT_EN - when defined, a stage that does not report
//            ready within TIMEOUT_CYCLES parks the sequencer in FAULT. When
//            undefined, stages are waited on indefinitely and ERR/ERR_STAGE
//            are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module reset_sequencer #(
    parameter int  NUM_STAGES     = 4,
    parameter int  HOLD_CYCLES    = 16,
    parameter int  GAP_CYCLES     = 8,
    parameter int  CNT_W          = 16,
    parameter int  TIMEOUT_CYCLES = 1024,
    localparam int IDX_W          = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  SW_RST_REQ,
    input  logic [NUM_STAGES-1:0] STAGE_RDY,
    output logic [NUM_STAGES-1:0] STAGE_RST,
    output logic                  SEQ_BUSY,
    output logic                  SEQ_DONE,
    output logic                  ERR,
    output logic [IDX_W-1:0]      ERR_STAGE
);

    localparam logic [2:0] c_ST_HOLD  = 3'd0;
    localparam logic [2:0] c_ST_WAIT  = 3'd1;
    localparam logic [2:0] c_ST_GAP   = 3'd2;
    localparam logic [2:0] c_ST_DONE  = 3'd3;
`ifdef RST_SEQ_TIMEOUT_EN
    localparam logic [2:0] c_ST_FAULT = 3'd4;
    localparam logic [CNT_W-1:0] c_TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    localparam logic [CNT_W-1:0] c_HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    // Only meaningful when GAP_CYCLES >= 1; the zero-gap case never enters GAP.
    localparam logic [CNT_W-1:0] c_GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] c_IDX_LAST  = IDX_W'(NUM_STAGES - 1);

    logic [2:0]            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic [NUM_STAGES-1:0] r_stage_rst;
    logic                  r_busy;
    logic                  r_done;

    logic [2:0]            w_state_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [IDX_W-1:0]      w_idx_nxt;
    logic [NUM_STAGES-1:0] w_rst_nxt;
    logic                  w_busy_nxt;
    logic                  w_done_nxt;
    logic [IDX_W-1:0]      w_idx_inc;

`ifdef RST_SEQ_TIMEOUT_EN
    logic                  r_err;
    logic [IDX_W-1:0]      r_err_stage;
    logic                  w_err_nxt;
    logic [IDX_W-1:0]      w_err_stage_nxt;
`else
    // Timeout length has no effect in this build.
    logic [CNT_W-1:0]      w_unused_timeout;
    assign w_unused_timeout = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    assign w_idx_inc = r_idx + 1'b1;

    // ------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_rst_nxt   = r_stage_rst;
`ifdef RST_SEQ_TIMEOUT_EN
        w_err_nxt       = r_err;
        w_err_stage_nxt = r_err_stage;
`endif

        if (SW_RST_REQ) begin
            // Restart overrides every other transition, including a DONE
            // ready-drop or a timeout in the same cycle.
            w_state_nxt = c_ST_HOLD;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
            w_rst_nxt   = '1;
`ifdef RST_SEQ_TIMEOUT_EN
            w_err_nxt       = 1'b0;
            w_err_stage_nxt = '0;
`endif
        end else begin
            case (r_state)
                c_ST_HOLD: begin
                    if (r_cnt == c_HOLD_LAST) begin
                        w_rst_nxt[0] = 1'b0;
                        w_idx_nxt    = '0;
                        w_cnt_nxt    = '0;
                        w_state_nxt  = c_ST_WAIT;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end

                c_ST_WAIT: begin
                    if (STAGE_RDY[r_idx]) begin
                        if (r_idx == c_IDX_LAST) begin
                            w_state_nxt = c_ST_DONE;
                        end else if (GAP_CYCLES == 0) begin
                            // No gap: next stage released on this same edge.
                            w_rst_nxt[w_idx_inc] = 1'b0;
                            w_idx_nxt            = w_idx_inc;
                            w_cnt_nxt            = '0;
                        end else begin
                            w_cnt_nxt   = '0;
                            w_state_nxt = c_ST_GAP;
                        end
                    end
`ifdef RST_SEQ_TIMEOUT_EN
                    else if (r_cnt == c_TO_LAST) begin
                        w_state_nxt     = c_ST_FAULT;
                        w_err_nxt       = 1'b1;
                        w_err_stage_nxt = r_idx;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
`endif
                end

                c_ST_GAP: begin
                    if (r_cnt == c_GAP_LAST) begin
                        w_rst_nxt[w_idx_inc] = 1'b0;
                        w_idx_nxt            = w_idx_inc;
                        w_cnt_nxt            = '0;
                        w_state_nxt          = c_ST_WAIT;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end

                c_ST_DONE: begin
                    // Any domain losing ready re-runs the full sequence.
                    if (!(&STAGE_RDY)) begin
                        w_state_nxt = c_ST_HOLD;
                        w_cnt_nxt   = '0;
                        w_idx_nxt   = '0;
                        w_rst_nxt   = '1;
                    end
                end

`ifdef RST_SEQ_TIMEOUT_EN
                c_ST_FAULT: begin
                    // Parked until restart or RST; resets hold their value.
                end
`endif

                default: begin
                    w_state_nxt = c_ST_HOLD;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_rst_nxt   = '1;
                end
            endcase
        end

        w_done_nxt = (w_state_nxt == c_ST_DONE);
`ifdef RST_SEQ_TIMEOUT_EN
        w_busy_nxt = !w_done_nxt && (w_state_nxt != c_ST_FAULT);
`else
        w_busy_nxt = !w_done_nxt;
`endif
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= c_ST_HOLD;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_stage_rst <= '1;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_stage_rst <= w_rst_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

`ifdef RST_SEQ_TIMEOUT_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_err       <= 1'b0;
            r_err_stage <= '0;
        end else begin
            r_err       <= w_err_nxt;
            r_err_stage <= w_err_stage_nxt;
        end
    end

    assign ERR       = r_err;
    assign ERR_STAGE = r_err_stage;
`else
    assign ERR       = 1'b0;
    assign ERR_STAGE = '0;
`endif

    assign STAGE_RST = r_stage_rst;
    assign SEQ_BUSY  = r_busy;
    assign SEQ_DONE  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_reset_sequencer
// Purpose  : Self-checking bench for reset_sequencer. Three instances:
//            A - default parameters, ready returned through a 2-flop delay
//            B - zero gap, ready tied to ~STAGE_RST
//            C - TIMEOUT_CYCLES=10, stage 1 never reports ready
// Revision : 1.0 - initial release
// ============================================================================
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       sw_a, sw_c, rst_c;
    logic [3:0] rdy_a, rdy_b, rdy_c;
    logic [3:0] srst_a, srst_b, srst_c;
    logic       busy_a, done_a, err_a;
    logic       busy_b, done_b, err_b;
    logic       busy_c, done_c, err_c;
    logic [1:0] estg_a, estg_b, estg_c;

    // Domain model for A: ready follows release two cycles later.
    logic [3:0] r_d1, r_d2;
    logic [3:0] mask_a, force_a;

    int e;       // edge index relative to E0
    int n_cmp;
    int n_bad;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        r_d1 <= ~srst_a;
        r_d2 <= r_d1;
    end

    assign rdy_a = (r_d2 & mask_a) | force_a;
    assign rdy_b = ~srst_b;
    assign rdy_c = ~srst_c & 4'b1101;

    reset_sequencer u_a (
        .CLK(clk), .RST(rst), .SW_RST_REQ(sw_a), .STAGE_RDY(rdy_a),
        .STAGE_RST(srst_a), .SEQ_BUSY(busy_a), .SEQ_DONE(done_a),
        .ERR(err_a), .ERR_STAGE(estg_a)
    );

    reset_sequencer #(.GAP_CYCLES(0)) u_b (
        .CLK(clk), .RST(rst), .SW_RST_REQ(1'b0), .STAGE_RDY(rdy_b),
        .STAGE_RST(srst_b), .SEQ_BUSY(busy_b), .SEQ_DONE(done_b),
        .ERR(err_b), .ERR_STAGE(estg_b)
    );

    reset_sequencer #(.TIMEOUT_CYCLES(10)) u_c (
        .CLK(clk), .RST(rst_c), .SW_RST_REQ(sw_c), .STAGE_RDY(rdy_c),
        .STAGE_RST(srst_c), .SEQ_BUSY(busy_c), .SEQ_DONE(done_c),
        .ERR(err_c), .ERR_STAGE(estg_c)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic to_edge(input int t);
        while (e < t) tick();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @E0+%0d: got %0h expected %0h", name, e, act, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [3:0] r, input logic b, input logic d);
        chk({tag, ".A.rst"},  {28'd0, srst_a}, {28'd0, r});
        chk({tag, ".A.busy"}, {31'd0, busy_a}, {31'd0, b});
        chk({tag, ".A.done"}, {31'd0, done_a}, {31'd0, d});
    endtask

    typedef struct {
        int         e;
        logic [3:0] ra;
        logic       ba;
        logic       da;
        logic [3:0] rb;
        logic       db;
    } vec_t;

    vec_t tbl[15];

    initial begin
        int h, s1, s2, r, t0;

        tbl[0]  = '{0,  4'b1111, 1'b1, 1'b0, 4'b1111, 1'b0};
        tbl[1]  = '{15, 4'b1111, 1'b1, 1'b0, 4'b1111, 1'b0};
        tbl[2]  = '{16, 4'b1110, 1'b1, 1'b0, 4'b1110, 1'b0};
        tbl[3]  = '{17, 4'b1110, 1'b1, 1'b0, 4'b1100, 1'b0};
        tbl[4]  = '{18, 4'b1110, 1'b1, 1'b0, 4'b1000, 1'b0};
        tbl[5]  = '{19, 4'b1110, 1'b1, 1'b0, 4'b0000, 1'b0};
        tbl[6]  = '{20, 4'b1110, 1'b1, 1'b0, 4'b0000, 1'b1};
        tbl[7]  = '{26, 4'b1110, 1'b1, 1'b0, 4'b0000, 1'b1};
        tbl[8]  = '{27, 4'b1100, 1'b1, 1'b0, 4'b0000, 1'b1};
        tbl[9]  = '{37, 4'b1100, 1'b1, 1'b0, 4'b0000, 1'b1};
        tbl[10] = '{38, 4'b1000, 1'b1, 1'b0, 4'b0000, 1'b1};
        tbl[11] = '{48, 4'b1000, 1'b1, 1'b0, 4'b0000, 1'b1};
        tbl[12] = '{49, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1};
        tbl[13] = '{51, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1};
        tbl[14] = '{52, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b1};

        n_cmp   = 0;
        n_bad   = 0;
        e       = -3;
        rst     = 1'b1;
        rst_c   = 1'b1;
        sw_a    = 1'b0;
        sw_c    = 1'b0;
        mask_a  = 4'b1111;
        force_a = 4'b0000;

        // RST high for three edges; the third is E0.
        repeat (3) tick();
        rst = 1'b0;

        // Basic sequencing (A) and zero-gap sequencing (B).
        for (int i = 0; i < 15; i++) begin
            to_edge(tbl[i].e);
            chk_a($sformatf("seq[%0d]", i), tbl[i].ra, tbl[i].ba, tbl[i].da);
            chk($sformatf("seq[%0d].A.err", i), {31'd0, err_a}, 32'd0);
            chk($sformatf("seq[%0d].B.rst", i), {28'd0, srst_b}, {28'd0, tbl[i].rb});
            chk($sformatf("seq[%0d].B.done", i), {31'd0, done_b}, {31'd0, tbl[i].db});
        end

        // Ready drop in DONE re-runs the whole sequence.
        mask_a = 4'b1011;
        tick();
        mask_a = 4'b1111;
        h = e;
        chk_a("drop", 4'b1111, 1'b1, 1'b0);
        to_edge(h + 15); chk_a("drop+15", 4'b1111, 1'b1, 1'b0);
        to_edge(h + 16); chk_a("drop+16", 4'b1110, 1'b1, 1'b0);
        to_edge(h + 27); chk_a("drop+27", 4'b1100, 1'b1, 1'b0);
        to_edge(h + 52); chk_a("drop+52", 4'b0000, 1'b0, 1'b1);

        // Software restart from DONE, then again while in GAP after stage 1.
        sw_a = 1'b1;
        tick();
        sw_a = 1'b0;
        s1 = e;
        chk_a("swdone", 4'b1111, 1'b1, 1'b0);
        to_edge(s1 + 27); chk_a("sw1+27", 4'b1100, 1'b1, 1'b0);
        to_edge(s1 + 32);
        sw_a = 1'b1;
        tick();
        sw_a = 1'b0;
        s2 = e;
        chk_a("swgap", 4'b1111, 1'b1, 1'b0);
        to_edge(s2 + 15); chk_a("sw2+15", 4'b1111, 1'b1, 1'b0);
        to_edge(s2 + 16); chk_a("sw2+16", 4'b1110, 1'b1, 1'b0);
        to_edge(s2 + 26); chk_a("sw2+26", 4'b1110, 1'b1, 1'b0);
        to_edge(s2 + 27); chk_a("sw2+27", 4'b1100, 1'b1, 1'b0);

        // RST together with SW_RST_REQ, then ready chatter during HOLD.
        rst     = 1'b1;
        sw_a    = 1'b1;
        force_a = 4'b1111;
        tick();
        rst  = 1'b0;
        sw_a = 1'b0;
        r = e;
        chk_a("rst+sw", 4'b1111, 1'b1, 1'b0);
        chk("rst+sw.A.err", {31'd0, err_a}, 32'd0);
        to_edge(r + 4);  force_a = 4'b0101;
        to_edge(r + 7);  force_a = 4'b1010;
        to_edge(r + 10); force_a = 4'b0000;
        to_edge(r + 15); chk_a("hold+15", 4'b1111, 1'b1, 1'b0);
        to_edge(r + 16); chk_a("hold+16", 4'b1110, 1'b1, 1'b0);
        to_edge(r + 27); chk_a("hold+27", 4'b1100, 1'b1, 1'b0);

        // Stage 1 never reports ready (C).
        rst_c = 1'b0;
        t0 = e;
        to_edge(t0 + 16);
        chk("to+16.C.rst", {28'd0, srst_c}, 32'b1110);
        to_edge(t0 + 25);
        chk("to+25.C.rst", {28'd0, srst_c}, 32'b1100);
        to_edge(t0 + 34);
        chk("to+34.C.err", {31'd0, err_c}, 32'd0);
        chk("to+34.C.busy", {31'd0, busy_c}, 32'd1);
        to_edge(t0 + 35);
        chk("to+35.C.rst", {28'd0, srst_c}, 32'b1100);
        chk("to+35.C.done", {31'd0, done_c}, 32'd0);
`ifdef RST_SEQ_TIMEOUT_EN
        chk("to+35.C.err", {31'd0, err_c}, 32'd1);
        chk("to+35.C.estg", {30'd0, estg_c}, 32'd1);
        chk("to+35.C.busy", {31'd0, busy_c}, 32'd0);
        to_edge(t0 + 40);
        chk("to+40.C.err", {31'd0, err_c}, 32'd1);
        chk("to+40.C.rst", {28'd0, srst_c}, 32'b1100);
`else
        chk("to+35.C.err", {31'd0, err_c}, 32'd0);
        chk("to+35.C.estg", {30'd0, estg_c}, 32'd0);
        chk("to+35.C.busy", {31'd0, busy_c}, 32'd1);
`endif
        sw_c = 1'b1;
        tick();
        sw_c = 1'b0;
        chk("clr.C.err", {31'd0, err_c}, 32'd0);
        chk("clr.C.rst", {28'd0, srst_c}, 32'b1111);
        chk("clr.C.busy", {31'd0, busy_c}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at E0+%0d", e);
        $fatal(1);
    end

endmodule
`default_nettype wire
